fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

- Parametrised multicycle program-counter and fetch/commit sequencer for the bbtron CPU family.
- Replaces the single-cycle program counter plus PC-source/jump selection.
- Supports configurable address width, instruction-memory read latency and reset vector.
- Adds explicit halt/resume, wait-for-switch-input stalls and a single-cycle commit strobe that gates register-bench and data-memory writes.

## Interface
Parameters:
- ADDR_WIDTH, 16, PC and instruction-address width.
- JUMP_WIDTH, 26, width of the jump target field.
- IMEM_LATENCY, 1, instruction-memory read latency in cycles; legal range 1–7.
- RESET_VECTOR, 0, PC value loaded on reset; ADDR_WIDTH bits.

Ports:
- clock, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- hlt, in, 1, decoded halt instruction; sampled in EXEC.
- resume, in, 1, leave HALT; sampled only in HALT.
- in_req, in, 1, current instruction reads switches; sampled in EXEC.
- in_ack, in, 1, switch value confirmed; sampled only in WAIT_IN.
- jump, in, 1, unconditional jump; sampled in EXEC.
- jump_target, in, JUMP_WIDTH, absolute word address; the low ADDR_WIDTH bits are used.
- branch_taken, in, 1, Branch AND zero; sampled in EXEC.
- branch_offset, in, ADDR_WIDTH, two's-complement word offset.
- imem_addr, out, ADDR_WIDTH, current PC / instruction address.
- pc_plus1, out, ADDR_WIDTH, imem_addr+1 modulo 2^ADDR_WIDTH.
- commit, out, 1, one-cycle strobe; the instruction completes this cycle.
- halted, out, 1, high while in HALT.
- state, out, 3, FSM state encoding, for debug.

## Operation
- FSM states:
  - RST: entered only by reset; leaves to FETCH on the first clock after reset deasserts.
  - FETCH: 1 cycle; address presented on imem_addr.
  - WAIT_MEM: IMEM_LATENCY−1 cycles, driven by a down-counter; skipped when IMEM_LATENCY=1.
  - EXEC: the instruction is valid and control inputs are evaluated.
  - WAIT_IN: stalled until input is confirmed.
  - HALT: stopped until resume.
- EXEC priority, highest first:
  1. hlt: go to HALT, no commit, PC held on the halt instruction.
  2. in_req with in_done clear: go to WAIT_IN, no commit.
  3. jump: PC ← jump_target[ADDR_WIDTH-1:0].
  4. branch_taken: PC ← pc+1+branch_offset, modulo 2^ADDR_WIDTH.
  5. Otherwise: PC ← pc+1, modulo 2^ADDR_WIDTH.
  - Cases 3–5 assert commit, clear in_done and go to FETCH.
- WAIT_IN: in_ack sets the internal flag in_done and returns to EXEC, which then commits exactly once.
- HALT: resume sets PC ← pc+1 and goes to FETCH; the halt instruction itself never commits.
- Ignored inputs:
  - in_ack outside WAIT_IN.
  - resume outside HALT.
  - All control inputs outside EXEC.
- Arithmetic is unsigned modulo 2^ADDR_WIDTH; overflow is discarded silently.

## Timing
- Reset values (applied asynchronously):
  - pc = imem_addr = RESET_VECTOR.
  - pc_plus1 = RESET_VECTOR+1.
  - commit = 0, halted = 0, in_done = 0, state = RST, latency counter = 0.
- Reset asserted in any state aborts the instruction in flight immediately: no commit, outputs at reset values in the same cycle.
- imem_addr is registered and updates on the clock edge leaving EXEC (or HALT on resume).
- Normal instruction: 1 + IMEM_LATENCY cycles. The first commit after reset release is at cycle IMEM_LATENCY+1, counting the RST exit as cycle 0.
- commit is combinational from state and inputs in EXEC and is never high for two consecutive cycles.
- halted is registered and high from the first HALT cycle until the cycle after resume is sampled.
- Simultaneous events:
  - hlt+jump, or hlt+in_req: halt wins.
  - jump+branch_taken: jump wins.
  - reset+resume: reset wins.

## Structure
- Shared package bbtron_pkg holds:
  - the fsm_state_t enum (RST, FETCH, WAIT_MEM, EXEC, WAIT_IN, HALT) with fixed 3-bit encodings;
  - the maximum IMEM_LATENCY constant.
- One natural sub-module: next_pc_calc, purely combinational. It takes pc, jump, jump_target, branch_taken and branch_offset and produces next_pc using the priority above.
- The FSM, latency counter and in_done flag live in fetch_sequencer itself.

## Test plan
- RESET_VECTOR=0x0010, IMEM_LATENCY=1, no control inputs: imem_addr=0x0010 during reset; commit at cycle 2; imem_addr becomes 0x0011 after that commit.
- PC forced to 0xFFFF, sequential execution: after commit, imem_addr=0x0000 and pc_plus1=0x0001.
- pc=0x0020, branch_taken=1, branch_offset=0xFFFD: next imem_addr=0x001E. With jump=1 and jump_target=0x2000040 in the same cycle: next imem_addr=0x0040.
- pc=0x0020, hlt=1 and jump=1 together: halted=1, no commit, imem_addr stays 0x0020 for 10 cycles; resume pulse gives FETCH at 0x0021, halted=0.
- in_req=1 held: WAIT_IN for 5 cycles with commit=0; in_ack pulse gives exactly one commit, then fetch of pc+1; in_ack pulsed during FETCH has no effect.
- IMEM_LATENCY=3: commit every 4 cycles. Reset asserted mid-WAIT_MEM: state=RST, imem_addr=RESET_VECTOR and commit=0 in the same cycle, before any clock edge.

Source files
------------

// File: rtl/bbtron_pkg.sv
// Shared types and limits for the bbtron fetch/commit sequencer.
package bbtron_pkg;

  typedef enum logic [2:0] {
    RST      = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    EXEC     = 3'd3,
    WAIT_IN  = 3'd4,
    HALT     = 3'd5
  } fsm_state_t;

  localparam int unsigned MAX_IMEM_LATENCY = 7;
  localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump over branch over sequential.
module next_pc_calc #(
  parameter int ADDR_WIDTH = 16,
  parameter int JUMP_WIDTH = 26
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  jump_i,
  input  logic [JUMP_WIDTH-1:0] jump_target_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_offset_i,
  output logic [ADDR_WIDTH-1:0] next_pc_o
);

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  unused_tgt_hi;

  assign pc_inc = pc_i + ADDR_WIDTH'(1);
  // Only the low address bits of the jump field reach the PC.
  assign unused_tgt_hi = ^jump_target_i[JUMP_WIDTH-1:ADDR_WIDTH];

  always_comb begin
    next_pc_o = pc_inc;
    if (jump_i) begin
      next_pc_o = jump_target_i[ADDR_WIDTH-1:0];
    end else if (branch_taken_i) begin
      next_pc_o = pc_inc + branch_offset_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle PC and fetch/commit sequencer with halt and input stalls.
module fetch_sequencer
  import bbtron_pkg::*;
#(
  parameter int              ADDR_WIDTH   = 16,
  parameter int              JUMP_WIDTH   = 26,
  parameter int              IMEM_LATENCY = 1,
  parameter [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hlt,
  input  logic                  resume,
  input  logic                  in_req,
  input  logic                  in_ack,
  input  logic                  jump,
  input  logic [JUMP_WIDTH-1:0] jump_target,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic                  commit,
  output logic                  halted,
  output logic [2:0]            state
);

  fsm_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   in_done_q, in_done_d;
  logic                   halted_q;
  logic [ADDR_WIDTH-1:0]  next_pc;

  next_pc_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .JUMP_WIDTH(JUMP_WIDTH)
  ) u_next_pc (
    .pc_i           (pc_q),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .branch_taken_i (branch_taken),
    .branch_offset_i(branch_offset),
    .next_pc_o      (next_pc)
  );

  assign imem_addr = pc_q;
  assign pc_plus1  = pc_q + ADDR_WIDTH'(1);
  assign halted    = halted_q;
  assign state     = state_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    in_done_d = in_done_q;
    commit    = 1'b0;
    unique case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        if (IMEM_LATENCY > 1) begin
          state_d = WAIT_MEM;
          cnt_d   = LAT_CNT_W'(IMEM_LATENCY - 2);
        end else begin
          state_d = EXEC;
        end
      end
      WAIT_MEM: begin
        if (cnt_q == '0) state_d = EXEC;
        else             cnt_d   = cnt_q - 1'b1;
      end
      EXEC: begin
        if (hlt) begin
          state_d = HALT;
        end else if (in_req && !in_done_q) begin
          state_d = WAIT_IN;
        end else begin
          commit    = 1'b1;
          pc_d      = next_pc;
          in_done_d = 1'b0;
          state_d   = FETCH;
        end
      end
      WAIT_IN: begin
        if (in_ack) begin
          in_done_d = 1'b1;
          state_d   = EXEC;
        end
      end
      HALT: begin
        // The halt instruction is skipped, never committed.
        if (resume) begin
          pc_d    = pc_plus1;
          state_d = FETCH;
        end
      end
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RST;
      pc_q      <= RESET_VECTOR;
      cnt_q     <= '0;
      in_done_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      in_done_q <= in_done_d;
      halted_q  <= (state_d == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench: two sequencer configs against an instruction-level model.
module tb_fetch_sequencer;

  localparam int AW = 16;
  localparam int JW = 26;

  logic          clock = 1'b0;
  logic          reset;
  logic          hlt[2], resume[2], in_req[2], in_ack[2];
  logic          jump[2], branch_taken[2];
  logic [JW-1:0] jump_target[2];
  logic [AW-1:0] branch_offset[2];
  logic [AW-1:0] imem_addr[2], pc_plus1[2];
  logic          commit[2], halted[2];
  logic [2:0]    state[2];

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] m_pc[2];
  int            m_stage[2];
  bit            m_rst[2], m_halt[2], m_wait[2], m_done[2];
  int            n_commit[2];

  always #5 clock = ~clock;

  fetch_sequencer #(
    .ADDR_WIDTH(AW), .JUMP_WIDTH(JW),
    .IMEM_LATENCY(1), .RESET_VECTOR(16'h0010)
  ) dut0 (
    .clock(clock), .reset(reset),
    .hlt(hlt[0]), .resume(resume[0]),
    .in_req(in_req[0]), .in_ack(in_ack[0]),
    .jump(jump[0]), .jump_target(jump_target[0]),
    .branch_taken(branch_taken[0]),
    .branch_offset(branch_offset[0]),
    .imem_addr(imem_addr[0]), .pc_plus1(pc_plus1[0]),
    .commit(commit[0]), .halted(halted[0]),
    .state(state[0])
  );

  fetch_sequencer #(
    .ADDR_WIDTH(AW), .JUMP_WIDTH(JW),
    .IMEM_LATENCY(3), .RESET_VECTOR(16'hFFFE)
  ) dut1 (
    .clock(clock), .reset(reset),
    .hlt(hlt[1]), .resume(resume[1]),
    .in_req(in_req[1]), .in_ack(in_ack[1]),
    .jump(jump[1]), .jump_target(jump_target[1]),
    .branch_taken(branch_taken[1]),
    .branch_offset(branch_offset[1]),
    .imem_addr(imem_addr[1]), .pc_plus1(pc_plus1[1]),
    .commit(commit[1]), .halted(halted[1]),
    .state(state[1])
  );

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [AW-1:0] rv(int k);
    return (k == 0) ? 16'h0010 : 16'hFFFE;
  endfunction

  // 0 RST, 1 FETCH, 2 WAIT_MEM, 3 EXEC, 4 WAIT_IN, 5 HALT
  function automatic int exp_state(int k);
    if (m_rst[k])             return 0;
    if (m_halt[k])            return 5;
    if (m_wait[k])            return 4;
    if (m_stage[k] == 0)      return 1;
    if (m_stage[k] < lat(k))  return 2;
    return 3;
  endfunction

  function automatic bit exp_commit(int k);
    return exp_state(k) == 3 && !hlt[k] && !(in_req[k] && !m_done[k]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = rv(k); m_stage[k] = 0; m_rst[k] = 1;
      m_halt[k] = 0; m_wait[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state%0d", k), 32'(state[k]), exp_state(k));
      chk($sformatf("addr%0d", k), 32'(imem_addr[k]), 32'(m_pc[k]));
      chk($sformatf("plus1_%0d", k), 32'(pc_plus1[k]),
          32'(AW'(m_pc[k] + 16'd1)));
      chk($sformatf("commit%0d", k), 32'(commit[k]), 32'(exp_commit(k)));
      chk($sformatf("halted%0d", k), 32'(halted[k]), 32'(m_halt[k]));
      if (commit[k]) n_commit[k]++;
    end
  endtask

  task automatic step_models();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = rv(k); m_rst[k] = 1; m_stage[k] = 0;
        m_halt[k] = 0; m_wait[k] = 0; m_done[k] = 0;
      end else if (m_rst[k]) begin
        m_rst[k] = 0; m_stage[k] = 0;
      end else if (m_halt[k]) begin
        if (resume[k]) begin
          m_pc[k] = m_pc[k] + 16'd1; m_halt[k] = 0; m_stage[k] = 0;
        end
      end else if (m_wait[k]) begin
        if (in_ack[k]) begin
          m_wait[k] = 0; m_done[k] = 1;
        end
      end else if (m_stage[k] < lat(k)) begin
        m_stage[k]++;
      end else if (hlt[k]) begin
        m_halt[k] = 1;
      end else if (in_req[k] && !m_done[k]) begin
        m_wait[k] = 1;
      end else begin
        if (jump[k])              m_pc[k] = jump_target[k][AW-1:0];
        else if (branch_taken[k]) m_pc[k] = m_pc[k] + 16'd1 + branch_offset[k];
        else                      m_pc[k] = m_pc[k] + 16'd1;
        m_done[k] = 0; m_stage[k] = 0;
      end
    end
  endtask

  task automatic zero_inputs();
    for (int k = 0; k < 2; k++) begin
      hlt[k] = 0; resume[k] = 0; in_req[k] = 0; in_ack[k] = 0;
      jump[k] = 0; branch_taken[k] = 0;
      jump_target[k] = '0; branch_offset[k] = '0;
    end
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      hlt[k]          = ($urandom % 12 == 0) && !m_done[k];
      resume[k]       = ($urandom % 4 == 0);
      in_req[k]       = ($urandom % 5 == 0);
      in_ack[k]       = ($urandom % 3 == 0);
      jump[k]         = ($urandom % 6 == 0);
      branch_taken[k] = ($urandom % 4 == 0);
      jump_target[k]  = JW'($urandom);
      if ($urandom % 4 == 0) jump_target[k][AW-1:0] = 16'hFFFF;
      branch_offset[k] = AW'($urandom);
      if ($urandom % 4 == 0) branch_offset[k] = 16'hFFFD;
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    step_models();
    #1;
  endtask

  // Asserts reset between edges and checks the asynchronous effect at once.
  task automatic do_reset();
    zero_inputs();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_state%0d", k), 32'(state[k]), 0);
      chk($sformatf("rst_addr%0d", k), 32'(imem_addr[k]), 32'(rv(k)));
      chk($sformatf("rst_commit%0d", k), 32'(commit[k]), 0);
    end
    @(posedge clock);
    step_models();
    #1;
    reset = 1'b0;
    n_commit[0] = 0;
    n_commit[1] = 0;
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    zero_inputs();
    do_reset();

    repeat (3) cycle();
    chk("boot_commits0", 32'(n_commit[0]), 1);
    chk("boot_addr0", 32'(imem_addr[0]), 32'h0011);
    repeat (6) cycle();
    chk("seq_addr0", 32'(imem_addr[0]), 32'h0014);
    chk("wrap_commits1", 32'(n_commit[1]), 2);
    chk("wrap_addr1", 32'(imem_addr[1]), 32'h0000);
    chk("wrap_plus1_1", 32'(pc_plus1[1]), 32'h0001);

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      cycle();
      if ($urandom % 500 == 0) do_reset();
    end

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      zero_inputs();
      resume[1] = 1; in_ack[1] = 1;
      if (exp_state(1) == 2) found = 1;
      else cycle();
    end
    chk("found_wait_mem", 32'(found), 1);
    if (found) begin
      chk("pre_rst_state1", 32'(state[1]), 2);
      do_reset();
      repeat (4) cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
